// File: rtl/aes_key_candidate_search_if.sv
// Signal bundle between the key-search controller and the AES-128 ECB core.
// The controller is the master; the core is the slave.
interface aes_key_candidate_search_if;
  logic         aes_enc_dec;
  logic         aes_key_exp;
  logic         aes_start;
  logic [127:0] aes_key_in;
  logic [127:0] aes_text_in;
  logic         aes_key_val;
  logic         aes_text_val;
  logic [127:0] aes_text_out;
  logic         aes_busy;

  modport master (
    output aes_enc_dec, aes_key_exp, aes_start, aes_key_in, aes_text_in,
    input  aes_key_val, aes_text_val, aes_text_out, aes_busy
  );

  modport slave (
    input  aes_enc_dec, aes_key_exp, aes_start, aes_key_in, aes_text_in,
    output aes_key_val, aes_text_val, aes_text_out, aes_busy
  );
endinterface

// File: rtl/aes_key_candidate_search.sv
// Key-search controller: walks 2^NSEL candidate keys through the AES core,
// compares each ciphertext to the target, stops on match/exhaustion/abort/timeout.
module aes_key_candidate_search #(
  parameter int NSEL    = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 go,
  input  logic                 abort,
  input  logic [127:0]         plaintext,
  input  logic [127:0]         target_ct,
  input  logic [127:0]         cand0,
  input  logic [127:0]         cand1,
  output logic                 busy,
  output logic                 done,
  output logic                 found,
  output logic                 timeout_err,
  output logic [127:0]         key_found,
  output logic [NSEL-1:0]      iter_count,
  output logic [2:0]           fsm_state,
  aes_key_candidate_search_if.master core
);

  // Core handshake: aes_key_exp and aes_start are single-cycle requests; the core
  // answers with aes_key_val (level, only trusted while aes_busy=0) and a
  // one-cycle aes_text_val carrying aes_text_out. No back-pressure exists.

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    KEXP  = 3'd1,
    KWAIT = 3'd2,
    ENC   = 3'd3,
    EWAIT = 3'd4,
    CMP   = 3'd5,
    DONE  = 3'd6
  } state_t;

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  state_t state, state_d;

  logic [127:0]    pt_q, tgt_q, c0_q, c1_q, key_q, ct_q;
  logic [NSEL-1:0] idx;
  logic [WW-1:0]   wait_cnt;

  logic accept, wait_clr, wait_inc, ct_cap, hit, adv, to_hit;

  function automatic logic [127:0] build_key(input logic [NSEL-1:0] sel,
                                             input logic [127:0] c0,
                                             input logic [127:0] c1);
    logic [127:0] k;
    k = c0;
    for (int j = 0; j < NSEL; j++) begin
      if (sel[j]) k[8*j +: 8] = c1[8*j +: 8];
    end
    return k;
  endfunction

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_d;
  end

  always_comb begin
    state_d  = state;
    accept   = 1'b0;
    wait_clr = 1'b0;
    wait_inc = 1'b0;
    ct_cap   = 1'b0;
    hit      = 1'b0;
    adv      = 1'b0;
    to_hit   = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          accept  = 1'b1;
          state_d = KEXP;
        end
      end
      KEXP: begin
        wait_clr = 1'b1;
        state_d  = abort ? DONE : KWAIT;
      end
      KWAIT: begin
        if (core.aes_key_val && !core.aes_busy) begin
          state_d = ENC;
        end else if (wait_cnt == WAIT_LAST) begin
          to_hit  = 1'b1;
          state_d = DONE;
        end else begin
          wait_inc = 1'b1;
        end
      end
      ENC: begin
        wait_clr = 1'b1;
        state_d  = EWAIT;
      end
      EWAIT: begin
        if (core.aes_text_val) begin
          ct_cap  = 1'b1;
          state_d = CMP;
        end else if (wait_cnt == WAIT_LAST) begin
          to_hit  = 1'b1;
          state_d = DONE;
        end else begin
          wait_inc = 1'b1;
        end
      end
      CMP: begin
        // A match wins over abort and over the last-index exit.
        if (ct_q == tgt_q) begin
          hit     = 1'b1;
          state_d = DONE;
        end else if (abort || (idx == '1)) begin
          state_d = DONE;
        end else begin
          adv     = 1'b1;
          state_d = KEXP;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pt_q        <= '0;
      tgt_q       <= '0;
      c0_q        <= '0;
      c1_q        <= '0;
      key_q       <= '0;
      ct_q        <= '0;
      idx         <= '0;
      wait_cnt    <= '0;
      found       <= 1'b0;
      timeout_err <= 1'b0;
      key_found   <= '0;
    end else begin
      if (accept) begin
        pt_q        <= plaintext;
        tgt_q       <= target_ct;
        c0_q        <= cand0;
        c1_q        <= cand1;
        key_q       <= build_key('0, cand0, cand1);
        idx         <= '0;
        found       <= 1'b0;
        timeout_err <= 1'b0;
        key_found   <= '0;
      end
      if (wait_clr)      wait_cnt <= '0;
      else if (wait_inc) wait_cnt <= wait_cnt + WW'(1);
      if (ct_cap) ct_q <= core.aes_text_out;
      if (hit) begin
        found     <= 1'b1;
        key_found <= key_q;
      end
      if (to_hit) timeout_err <= 1'b1;
      // Next key is built here so aes_key_in is already stable on entry to KEXP.
      if (adv) begin
        idx   <= idx + NSEL'(1);
        key_q <= build_key(idx + NSEL'(1), c0_q, c1_q);
      end
    end
  end

  assign busy             = (state != IDLE) && (state != DONE);
  assign done             = (state == DONE);
  assign iter_count       = idx;
  assign fsm_state        = state;
  assign core.aes_enc_dec = 1'b0;
  assign core.aes_key_exp = (state == KEXP) && !abort;
  assign core.aes_start   = (state == ENC);
  assign core.aes_key_in  = key_q;
  assign core.aes_text_in = pt_q;

endmodule

// File: tb/tb_aes_key_candidate_search.sv
// Directed bench for aes_key_candidate_search with NSEL=4 and a toy behavioural
// cipher standing in for the AES core.
module tb_aes_key_candidate_search;
  localparam int NSEL    = 4;
  localparam int TIMEOUT = 1024;
  localparam int KLAT    = 5;
  localparam int ELAT    = 7;

  localparam logic [127:0] PT  = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] C0  = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] C1  = 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF;
  localparam logic [127:0] K0  = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] K5  = 128'h000102030405060708090A0B0CFD0EFF;
  localparam logic [127:0] NOHIT = 128'hDEADBEEFCAFEF00D0123456789ABCDEF;

  logic              clock, resetn, go, abort;
  logic [127:0]      plaintext, target_ct, cand0, cand1;
  logic              busy, done, found, timeout_err;
  logic [127:0]      key_found;
  logic [NSEL-1:0]   iter_count;
  logic [2:0]        fsm_state;

  aes_key_candidate_search_if core_if ();

  aes_key_candidate_search #(.NSEL(NSEL), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .resetn(resetn), .go(go), .abort(abort),
    .plaintext(plaintext), .target_ct(target_ct), .cand0(cand0), .cand1(cand1),
    .busy(busy), .done(done), .found(found), .timeout_err(timeout_err),
    .key_found(key_found), .iter_count(iter_count), .fsm_state(fsm_state),
    .core(core_if)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int kexp_total = 0;
  bit hang_key = 1'b0;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (core_if.aes_key_exp) kexp_total <= kexp_total + 1;
  end

  function automatic logic [127:0] toy_enc(input logic [127:0] k, input logic [127:0] p);
    logic [127:0] x;
    x = k ^ p;
    x = {x[114:0], x[127:115]} ^ 128'h5A5A5A5A_A5A5A5A5_3C3C3C3C_C3C3C3C3;
    x = x + {k[63:0], k[127:64]};
    return x;
  endfunction

  // behavioural core
  int           kcnt, ecnt;
  logic [127:0] key_lat;
  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      kcnt <= 0; ecnt <= 0; key_lat <= '0;
      core_if.aes_key_val  <= 1'b0;
      core_if.aes_text_val <= 1'b0;
      core_if.aes_text_out <= '0;
      core_if.aes_busy     <= 1'b0;
    end else begin
      core_if.aes_text_val <= 1'b0;
      if (core_if.aes_key_exp) begin
        kcnt <= KLAT; key_lat <= core_if.aes_key_in;
        core_if.aes_key_val <= 1'b0;
        core_if.aes_busy    <= 1'b1;
      end else if (kcnt != 0) begin
        kcnt <= kcnt - 1;
        if (kcnt == 1) begin
          core_if.aes_busy <= 1'b0;
          if (!hang_key) core_if.aes_key_val <= 1'b1;
        end
      end
      if (core_if.aes_start) begin
        ecnt <= ELAT;
        core_if.aes_busy <= 1'b1;
      end else if (ecnt != 0) begin
        ecnt <= ecnt - 1;
        if (ecnt == 1) begin
          core_if.aes_text_val <= 1'b1;
          core_if.aes_text_out <= toy_enc(key_lat, core_if.aes_text_in);
          core_if.aes_busy     <= 1'b0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  int t0;
  task automatic start_search(input logic [127:0] tgt);
    @(negedge clock);
    plaintext = PT; target_ct = tgt; cand0 = C0; cand1 = C1; go = 1'b1;
    @(negedge clock);
    go = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input string tag, input int limit, output int td);
    bit seen;
    seen = 1'b0;
    td = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clock);
      if (done) begin
        seen = 1'b1;
        td = cyc;
        break;
      end
    end
    check({tag, "_done_seen"}, 128'(seen), 128'd1);
  endtask

  int k0, td;
  bit sent_go, wait_ok;

  initial begin
    resetn = 1'b0; go = 1'b0; abort = 1'b0;
    plaintext = '0; target_ct = '0; cand0 = '0; cand1 = '0;
    repeat (3) @(negedge clock);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_done", 128'(done), 128'd0);
    check("rst_found", 128'(found), 128'd0);
    check("rst_iter", 128'(iter_count), 128'd0);
    check("rst_key_in", core_if.aes_key_in, 128'd0);
    resetn = 1'b1;

    // match on first candidate
    k0 = kexp_total;
    start_search(toy_enc(K0, PT));
    check("t1_busy", 128'(busy), 128'd1);
    check("t1_key_in", core_if.aes_key_in, K0);
    wait_done("t1", 200, td);
    check("t1_found", 128'(found), 128'd1);
    check("t1_iter", 128'(iter_count), 128'd0);
    check("t1_key_found", key_found, K0);
    check("t1_busy_at_done", 128'(busy), 128'd0);
    @(negedge clock);
    check("t1_done_one_cycle", 128'(done), 128'd0);
    check("t1_kexp", 128'(kexp_total - k0), 128'd1);

    // match on idx 5
    k0 = kexp_total;
    start_search(toy_enc(K5, PT));
    wait_done("t2", 500, td);
    check("t2_found", 128'(found), 128'd1);
    check("t2_iter", 128'(iter_count), 128'd5);
    check("t2_key_found", key_found, K5);
    @(negedge clock);
    check("t2_kexp", 128'(kexp_total - k0), 128'd6);

    // exhaustion
    k0 = kexp_total;
    start_search(NOHIT);
    wait_done("t3", 2000, td);
    check("t3_found", 128'(found), 128'd0);
    check("t3_iter", 128'(iter_count), 128'hF);
    check("t3_timeout", 128'(timeout_err), 128'd0);
    @(negedge clock);
    check("t3_kexp", 128'(kexp_total - k0), 128'd16);

    // key expansion never completes
    hang_key = 1'b1;
    start_search(toy_enc(K0, PT));
    wait_done("t4", 1500, td);
    check("t4_timeout", 128'(timeout_err), 128'd1);
    check("t4_found", 128'(found), 128'd0);
    check("t4_busy", 128'(busy), 128'd0);
    check("t4_latency_in_range", 128'((td - t0) >= 1023 && (td - t0) <= 1025), 128'd1);
    hang_key = 1'b0;
    @(negedge clock);

    // abort during candidate 3; a stray go while busy must be ignored
    k0 = kexp_total;
    sent_go = 1'b0;
    wait_ok = 1'b0;
    start_search(NOHIT);
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (go) go = 1'b0;
      if (!sent_go && iter_count == 1) begin
        target_ct = toy_enc(K0, PT);
        go = 1'b1;
        sent_go = 1'b1;
      end
      if (iter_count == 3 && fsm_state == 3'd2) begin
        abort = 1'b1;
        wait_ok = 1'b1;
        break;
      end
    end
    go = 1'b0;
    check("t5_reached_idx3", 128'(wait_ok), 128'd1);
    wait_done("t5", 200, td);
    check("t5_found", 128'(found), 128'd0);
    check("t5_iter", 128'(iter_count), 128'd3);
    abort = 1'b0;
    @(negedge clock);
    check("t5_kexp", 128'(kexp_total - k0), 128'd4);

    // reset while waiting for ciphertext
    wait_ok = 1'b0;
    start_search(NOHIT);
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (iter_count == 2 && fsm_state == 3'd4) begin
        wait_ok = 1'b1;
        break;
      end
    end
    check("t6_reached_ewait", 128'(wait_ok), 128'd1);
    #2 resetn = 1'b0;
    #1;
    check("t6_busy", 128'(busy), 128'd0);
    check("t6_iter", 128'(iter_count), 128'd0);
    check("t6_state", 128'(fsm_state), 128'd0);
    check("t6_key_in", core_if.aes_key_in, 128'd0);
    check("t6_text_in", core_if.aes_text_in, 128'd0);
    @(negedge clock);
    resetn = 1'b1;
    k0 = kexp_total;
    start_search(toy_enc(K0, PT));
    wait_done("t6b", 200, td);
    check("t6b_found", 128'(found), 128'd1);
    check("t6b_iter", 128'(iter_count), 128'd0);
    @(negedge clock);
    check("t6b_kexp", 128'(kexp_total - k0), 128'd1);

    // final report
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
